// File: rtl/axi_timer_if.sv
`default_nettype none
// ============================================================================
//  Module      : axi_timer_if
//  Description : AXI4-Lite channel bundle between a core manager and the timer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface axi_timer_if #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                    awvalid;
    logic                    awready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    wvalid;
    logic                    wready;
    logic [WIDTH-1:0]        wdata;
    logic [WIDTH/8-1:0]      wstrb;
    logic                    bvalid;
    logic                    bready;
    logic [1:0]              bresp;
    logic                    arvalid;
    logic                    arready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    rvalid;
    logic                    rready;
    logic [WIDTH-1:0]        rdata;
    logic [1:0]              rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface
`default_nettype wire

// File: rtl/axi_timer.sv
`default_nettype none
// ============================================================================
//  Module      : axi_timer
//  Description : AXI4-Lite prescaled 32-bit up-counter with top value, overflow
//                flag, one-shot mode and registered level interrupt.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_timer #(
    parameter int WIDTH          = 32,
    parameter int ADDR_WIDTH     = 5,
    parameter int PRESCALE_WIDTH = 16
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    output logic       irq,
    axi_timer_if.slave axi
);
    localparam logic [1:0] c_W_IDLE  = 2'd0;
    localparam logic [1:0] c_W_READY = 2'd1;
    localparam logic [1:0] c_W_RESP  = 2'd2;
    localparam logic [1:0] c_R_IDLE  = 2'd0;
    localparam logic [1:0] c_R_READY = 2'd1;
    localparam logic [1:0] c_R_RESP  = 2'd2;

    localparam logic [ADDR_WIDTH-3:0] c_IDX_CTRL     = 'd0;
    localparam logic [ADDR_WIDTH-3:0] c_IDX_STATUS   = 'd1;
    localparam logic [ADDR_WIDTH-3:0] c_IDX_PRESCALE = 'd2;
    localparam logic [ADDR_WIDTH-3:0] c_IDX_COUNT    = 'd3;
    localparam logic [ADDR_WIDTH-3:0] c_IDX_TOP      = 'd4;
    localparam logic [1:0]            c_SLVERR       = 2'b10;

    logic [1:0]                r_wstate, w_wstate_nxt;
    logic [1:0]                r_rstate, w_rstate_nxt;
    logic [1:0]                r_bresp, r_rresp;
    logic [WIDTH-1:0]          r_rdata, w_rdata;
    logic                      r_en, r_ie, r_oneshot, r_ovf, r_irq;
    logic [PRESCALE_WIDTH-1:0] r_prescale, r_pc;
    logic [WIDTH-1:0]          r_count, r_top;

    function automatic logic [WIDTH-1:0] f_merge(input logic [WIDTH-1:0]   old_v,
                                                 input logic [WIDTH-1:0]   new_v,
                                                 input logic [WIDTH/8-1:0] strb);
        for (int b = 0; b < WIDTH/8; b++)
            f_merge[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
    endfunction

    wire logic [ADDR_WIDTH-3:0] w_widx = axi.awaddr[ADDR_WIDTH-1:2];
    wire logic [ADDR_WIDTH-3:0] w_ridx = axi.araddr[ADDR_WIDTH-1:2];
    wire logic w_unused_addr_lsbs = ^{axi.awaddr[1:0], axi.araddr[1:0]};

    wire logic w_wr_fire   = (r_wstate == c_W_READY) & axi.awvalid & axi.wvalid;
    wire logic w_rd_fire   = (r_rstate == c_R_READY) & axi.arvalid;
    wire logic w_wr_err    = w_widx > c_IDX_TOP;
    wire logic w_rd_err    = w_ridx > c_IDX_TOP;
    wire logic w_wr_ctrl   = w_wr_fire & (w_widx == c_IDX_CTRL);
    wire logic w_wr_status = w_wr_fire & (w_widx == c_IDX_STATUS);
    wire logic w_wr_pre    = w_wr_fire & (w_widx == c_IDX_PRESCALE);
    wire logic w_wr_count  = w_wr_fire & (w_widx == c_IDX_COUNT);
    wire logic w_wr_top    = w_wr_fire & (w_widx == c_IDX_TOP);

    // A software COUNT write pre-empts the overflow that the tick would cause.
    wire logic w_tick     = r_en & (r_pc == r_prescale);
    wire logic w_wrap     = (r_count == r_top);
    wire logic w_ovf_evt  = w_tick & w_wrap & ~w_wr_count;
    wire logic w_ovf_clr  = w_wr_status & axi.wstrb[0] & axi.wdata[0];
    wire logic w_ctrl_ld  = w_wr_ctrl & axi.wstrb[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wstate <= c_W_IDLE;
            r_rstate <= c_R_IDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_rstate <= w_rstate_nxt;
        end
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            c_W_IDLE:  if (axi.awvalid && axi.wvalid) w_wstate_nxt = c_W_READY;
            c_W_READY: w_wstate_nxt = w_wr_fire ? c_W_RESP : c_W_IDLE;
            c_W_RESP:  if (axi.bready) w_wstate_nxt = c_W_IDLE;
            default:   w_wstate_nxt = c_W_IDLE;
        endcase
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            c_R_IDLE:  if (axi.arvalid) w_rstate_nxt = c_R_READY;
            c_R_READY: w_rstate_nxt = w_rd_fire ? c_R_RESP : c_R_IDLE;
            c_R_RESP:  if (axi.rready) w_rstate_nxt = c_R_IDLE;
            default:   w_rstate_nxt = c_R_IDLE;
        endcase
    end

    always_comb begin
        w_rdata = '0;
        case (w_ridx)
            c_IDX_CTRL:     w_rdata = {{(WIDTH-3){1'b0}}, r_oneshot, r_ie, r_en};
            c_IDX_STATUS:   w_rdata = {{(WIDTH-1){1'b0}}, r_ovf};
            c_IDX_PRESCALE: w_rdata = {{(WIDTH-PRESCALE_WIDTH){1'b0}}, r_prescale};
            c_IDX_COUNT:    w_rdata = r_count;
            c_IDX_TOP:      w_rdata = r_top;
            default:        w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bresp <= 2'b00;
            r_rresp <= 2'b00;
            r_rdata <= '0;
        end else begin
            if (w_wr_fire) r_bresp <= w_wr_err ? c_SLVERR : 2'b00;
            if (w_rd_fire) begin
                r_rresp <= w_rd_err ? c_SLVERR : 2'b00;
                r_rdata <= w_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en       <= 1'b0;
            r_ie       <= 1'b0;
            r_oneshot  <= 1'b0;
            r_ovf      <= 1'b0;
            r_irq      <= 1'b0;
            r_prescale <= '0;
            r_pc       <= '0;
            r_count    <= '0;
            r_top      <= '1;
        end else begin
            if (w_ctrl_ld)
                {r_oneshot, r_ie, r_en} <= axi.wdata[2:0];
            else if (w_ovf_evt && r_oneshot)
                r_en <= 1'b0;

            if (w_wr_ctrl)
                r_pc <= '0;
            else if (r_en)
                r_pc <= w_tick ? '0 : r_pc + 1'b1;

            if (w_wr_count)
                r_count <= f_merge(r_count, axi.wdata, axi.wstrb);
            else if (w_tick)
                r_count <= w_wrap ? '0 : r_count + 1'b1;

            if (w_wr_top)
                r_top <= f_merge(r_top, axi.wdata, axi.wstrb);

            if (w_wr_pre)
                for (int b = 0; b < PRESCALE_WIDTH/8; b++)
                    if (axi.wstrb[b]) r_prescale[b*8 +: 8] <= axi.wdata[b*8 +: 8];

            // Setting beats clearing when both land on the same edge.
            r_ovf <= w_ovf_evt | (r_ovf & ~w_ovf_clr);
            r_irq <= r_ovf & r_ie;
        end
    end

    assign irq         = r_irq;
    assign axi.awready = (r_wstate == c_W_READY);
    assign axi.wready  = (r_wstate == c_W_READY);
    assign axi.bvalid  = (r_wstate == c_W_RESP);
    assign axi.bresp   = r_bresp;
    assign axi.arready = (r_rstate == c_R_READY);
    assign axi.rvalid  = (r_rstate == c_R_RESP);
    assign axi.rdata   = r_rdata;
    assign axi.rresp   = r_rresp;
endmodule
`default_nettype wire

// File: tb/tb_axi_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_timer
//  Description : Directed and randomized checks of axi_timer against a model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_timer;
    localparam logic [4:0] A_CTRL = 5'h00, A_STATUS = 5'h04, A_PRE = 5'h08;
    localparam logic [4:0] A_COUNT = 5'h0C, A_TOP = 5'h10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic irq;
    int   cyc = 0;
    int   n_cmp = 0, n_fail = 0;
    bit   irq_hist [int];

    axi_timer_if #(.WIDTH(32), .ADDR_WIDTH(5)) axi ();
    axi_timer dut (.clk(clk), .rst_n(rst_n), .irq(irq), .axi(axi));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // irq_hist[e] holds irq as it stands after clock edge number e.
    always @(negedge clk) irq_hist[cyc] = irq;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Timer behaviour from the rules: after the enabling CTRL write at edge w,
    // tick k lands on edge w + k*(P+1); one overflow per TOP+1 ticks.
    task automatic model(input int p, input longint t, input longint c0, input bit os,
                         input longint dt, output longint cnt, output bit ovf, output bit en);
        longint k, first;
        k     = dt / (p + 1);
        first = t - c0 + 1;
        ovf   = (k >= first);
        en    = 1'b1;
        cnt   = (c0 + k) % (t + 1);
        if (os && k >= first) begin
            cnt = 0;
            en  = 1'b0;
        end
    endtask

    task automatic go_to(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp, output int wedge);
        int t;
        axi.awaddr = addr; axi.wdata = data; axi.wstrb = strb;
        axi.awvalid = 1'b1; axi.wvalid = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!axi.awready && t < 20);
        if (t >= 20) check("awready_timeout", axi.awready, 1);
        wedge = cyc + 1;
        @(negedge clk);
        axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.bready = 1'b1;
        t = 0;
        while (!axi.bvalid && t < 20) begin @(negedge clk); t++; end
        if (t >= 20) check("bvalid_timeout", axi.bvalid, 1);
        resp = axi.bresp;
        @(negedge clk);
        axi.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [4:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output int redge);
        int t;
        axi.araddr = addr; axi.arvalid = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!axi.arready && t < 20);
        if (t >= 20) check("arready_timeout", axi.arready, 1);
        redge = cyc + 1;
        @(negedge clk);
        axi.arvalid = 1'b0; axi.rready = 1'b1;
        t = 0;
        while (!axi.rvalid && t < 20) begin @(negedge clk); t++; end
        if (t >= 20) check("rvalid_timeout", axi.rvalid, 1);
        data = axi.rdata; resp = axi.rresp;
        @(negedge clk);
        axi.rready = 1'b0;
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] data);
        logic [1:0] rs; int w;
        axi_write(addr, data, 4'hF, rs, w);
    endtask

    task automatic rd_check(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        logic [31:0] d; logic [1:0] rs; int r;
        axi_read(addr, d, rs, r);
        check(tag, d, exp);
    endtask

    initial begin
        int w, w0, r, t_cnt, p, ie, os;
        longint top, c0, mc;
        bit mo, me;
        logic [31:0] d;
        logic [1:0] rs;

        axi.awvalid = 0; axi.awaddr = 0; axi.wvalid = 0; axi.wdata = 0; axi.wstrb = 0;
        axi.bready = 0; axi.arvalid = 0; axi.araddr = 0; axi.rready = 0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_irq", irq, 0);
        check("rst_awready", axi.awready, 0);
        check("rst_wready", axi.wready, 0);
        check("rst_arready", axi.arready, 0);
        check("rst_bvalid", axi.bvalid, 0);
        check("rst_rvalid", axi.rvalid, 0);
        check("rst_bresp", axi.bresp, 0);
        check("rst_rresp", axi.rresp, 0);
        check("rst_rdata", axi.rdata, 0);
        rst_n = 1'b1;
        @(negedge clk);

        axi_read(A_TOP, d, rs, r);
        check("rst_top", d, 32'hFFFF_FFFF);
        check("rst_top_rresp", rs, 2'b00);
        rd_check("rst_ctrl", A_CTRL, 0);
        rd_check("rst_count", A_COUNT, 0);
        rd_check("rst_status", A_STATUS, 0);
        rd_check("rst_prescale", A_PRE, 0);

        // Byte strobes and decode errors
        axi_write(A_COUNT, 32'h1234_5678, 4'b0011, rs, w);
        check("strb_bresp", rs, 2'b00);
        rd_check("strb_count", A_COUNT, 32'h0000_5678);
        axi_read(5'h18, d, rs, r);
        check("err_rresp", rs, 2'b10);
        check("err_rdata", d, 0);
        axi_write(5'h14, 32'hDEAD_BEEF, 4'hF, rs, w);
        check("err_bresp", rs, 2'b10);
        rd_check("err_top_kept", A_TOP, 32'hFFFF_FFFF);

        // Prescaled run with interrupt
        wr(A_COUNT, 0); wr(A_PRE, 3); wr(A_TOP, 4);
        axi_write(A_CTRL, 32'h3, 4'hF, rs, w);
        go_to(w + 25);
        check("pre_irq_before", irq_hist[w+20], 0);
        check("pre_irq_after", irq_hist[w+21], 1);
        axi_read(A_COUNT, d, rs, r);
        model(3, 4, 0, 0, r - 1 - w, mc, mo, me);
        check("pre_count", d, mc[31:0]);
        rd_check("pre_status", A_STATUS, 1);

        // W1C clear drops irq one cycle later
        wr(A_CTRL, 32'h2);
        axi_write(A_STATUS, 1, 4'hF, rs, w);
        check("w1c_irq_same", irq_hist[w], 1);
        check("w1c_irq_next", irq_hist[w+1], 0);
        rd_check("w1c_status", A_STATUS, 0);

        // W1C on the overflow edge: set wins
        wr(A_COUNT, 0); wr(A_PRE, 0); wr(A_TOP, 10);
        axi_write(A_CTRL, 32'h3, 4'hF, rs, w0);
        go_to(w0 + 9);
        axi_write(A_STATUS, 1, 4'hF, rs, w);
        check("w1c_align", w, w0 + 11);
        rd_check("w1c_set_wins", A_STATUS, 1);
        wr(A_CTRL, 0); wr(A_STATUS, 1);

        // COUNT write on the overflow tick: write wins, no OVF
        wr(A_COUNT, 0); wr(A_TOP, 20);
        axi_write(A_CTRL, 32'h1, 4'hF, rs, w0);
        go_to(w0 + 19);
        axi_write(A_COUNT, 3, 4'hF, rs, w);
        check("cw_align", w, w0 + 21);
        rd_check("cw_no_ovf", A_STATUS, 0);
        axi_read(A_COUNT, d, rs, r);
        check("cw_count", d, 3 + (r - 1 - w));
        wr(A_CTRL, 0); wr(A_STATUS, 1);

        // One-shot
        wr(A_COUNT, 0); wr(A_TOP, 2);
        axi_write(A_CTRL, 32'h5, 4'hF, rs, w0);
        go_to(w0 + 6);
        rd_check("os_ctrl", A_CTRL, 32'h4);
        rd_check("os_count", A_COUNT, 0);
        rd_check("os_status", A_STATUS, 1);
        check("os_irq_masked", irq_hist[w0+5], 0);

        // CTRL write on the one-shot auto-clear edge
        wr(A_STATUS, 1); wr(A_COUNT, 0);
        axi_write(A_CTRL, 32'h5, 4'hF, rs, w0);
        go_to(w0 + 1);
        axi_write(A_CTRL, 32'h5, 4'hF, rs, w);
        check("osc_align", w, w0 + 3);
        rd_check("osc_ctrl", A_CTRL, 32'h5);
        wr(A_CTRL, 0);

        // AW before W, delayed bready/rready
        axi.awaddr = A_TOP; axi.wdata = 32'hCAFE_0003; axi.wstrb = 4'hF; axi.awvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("aw_only_awready", axi.awready, 0);
            check("aw_only_wready", axi.wready, 0);
        end
        axi.wvalid = 1'b1;
        t_cnt = 0;
        do begin @(negedge clk); t_cnt++; end while (!axi.awready && t_cnt < 20);
        check("stall_awready", axi.awready, 1);
        check("stall_wready", axi.wready, 1);
        @(negedge clk);
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        check("stall_awready_once", axi.awready, 0);
        for (int i = 0; i < 5; i++) begin
            check("stall_bvalid_hold", axi.bvalid, 1);
            check("stall_bresp_hold", axi.bresp, 0);
            @(negedge clk);
        end
        axi.bready = 1'b1; @(negedge clk); axi.bready = 1'b0;
        check("stall_bvalid_drop", axi.bvalid, 0);
        axi.araddr = A_TOP; axi.arvalid = 1'b1;
        t_cnt = 0;
        do begin @(negedge clk); t_cnt++; end while (!axi.arready && t_cnt < 20);
        check("stall_arready", axi.arready, 1);
        @(negedge clk);
        axi.arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall_rvalid_hold", axi.rvalid, 1);
            check("stall_rdata_hold", axi.rdata, 32'hCAFE_0003);
            @(negedge clk);
        end
        axi.rready = 1'b1; @(negedge clk); axi.rready = 1'b0;
        check("stall_rvalid_drop", axi.rvalid, 0);

        // Reset while both responses are pending
        axi.awaddr = A_CTRL; axi.wdata = 32'h2; axi.wstrb = 4'hF;
        axi.awvalid = 1'b1; axi.wvalid = 1'b1;
        axi.araddr = A_TOP; axi.arvalid = 1'b1;
        t_cnt = 0;
        while (!(axi.bvalid && axi.rvalid) && t_cnt < 20) begin @(negedge clk); t_cnt++; end
        check("mid_bvalid_up", axi.bvalid, 1);
        check("mid_rvalid_up", axi.rvalid, 1);
        axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_irq_up", irq, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_bvalid_drop", axi.bvalid, 0);
        check("mid_rvalid_drop", axi.rvalid, 0);
        check("mid_irq_drop", irq, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd_check("mid_top", A_TOP, 32'hFFFF_FFFF);
        rd_check("mid_ctrl", A_CTRL, 0);

        // Randomized configurations against the model
        for (int it = 0; it < 16; it++) begin
            p  = $urandom_range(0, 3);
            os = $urandom_range(0, 1);
            ie = $urandom_range(0, 1);
            if (it % 4 == 3) begin
                top = 64'hFFFF_FFFF;
                c0  = top - $urandom_range(0, 6);
            end else begin
                top = $urandom_range(1, 7);
                c0  = $urandom_range(0, int'(top));
            end
            wr(A_CTRL, 0); wr(A_STATUS, 1);
            wr(A_PRE, p); wr(A_TOP, top[31:0]); wr(A_COUNT, c0[31:0]);
            axi_write(A_CTRL, {29'd0, os[0], ie[0], 1'b1}, 4'hF, rs, w);
            repeat ($urandom_range(0, 30)) @(negedge clk);
            axi_read(A_COUNT, d, rs, r);
            model(p, top, c0, os[0], r - 1 - w, mc, mo, me);
            check("rnd_count", d, mc[31:0]);
            check("rnd_irq", irq_hist[r], mo & ie[0]);
            axi_read(A_STATUS, d, rs, r);
            model(p, top, c0, os[0], r - 1 - w, mc, mo, me);
            check("rnd_status", d, {31'd0, mo});
            axi_read(A_CTRL, d, rs, r);
            model(p, top, c0, os[0], r - 1 - w, mc, mo, me);
            check("rnd_ctrl", d, {29'd0, os[0], ie[0], me});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/axi_timer.md
Name: axi_timer

Overview:
- AXI4-Lite subordinate (responder) timer peripheral, hung off the SoC crossbar alongside GPIO/UART.
- Drives timer0_int/timer1_int; two instances, one per line.
- Prescaled 32-bit up-counter with programmable top value, overflow flag, one-shot mode and level interrupt.
- Responds to transactions issued by the core's AXI4-Lite manager.

Parameters:
- WIDTH, 32, AXI data width; only 32 supported.
- ADDR_WIDTH, 5, subordinate byte-address width (offset within timer window).
- PRESCALE_WIDTH, 16, prescaler register width.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- irq  output  1  interrupt, level, registered
- axi  interface (axi4_lite subordinate modport)  WIDTH/ADDR_WIDTH  AXI4-Lite channels: awvalid/awready/awaddr, wvalid/wready/wdata/wstrb, bvalid/bready/bresp, arvalid/arready/araddr, rvalid/rready/rdata/rresp

Behaviour:
- Register map (byte offsets, addr[1:0] ignored):
  - 0x00 CTRL: [0] EN, [1] IE, [2] ONESHOT; other bits read 0.
  - 0x04 STATUS: [0] OVF, write-1-to-clear.
  - 0x08 PRESCALE: [PRESCALE_WIDTH-1:0].
  - 0x0C COUNT: R/W.
  - 0x10 TOP: R/W.
  - >=0x14: SLVERR (2'b10), write ignored, rdata=0.
- Reset values: all registers 0 except TOP=0xFFFFFFFF. Outputs: irq=0, awready=wready=arready=0, bvalid=rvalid=0, bresp=rresp=2'b00, rdata=0.
- Prescaler counter pc: while EN, pc increments each clk; when pc==PRESCALE, pc<=0 and tick=1 that cycle. PRESCALE=0 gives tick every cycle. EN=0 holds pc and COUNT; writing CTRL resets pc to 0.
- On tick: COUNT==TOP -> COUNT<=0, OVF<=1, and if ONESHOT then EN<=0; else COUNT<=COUNT+1 (wraps at 2^32 only if TOP=0xFFFFFFFF).
- irq <= OVF & IE (one-cycle register delay from flag/enable).
- Write channel FSM: W_IDLE -> W_RESP.
  - W_IDLE: when awvalid & wvalid, assert awready and wready for exactly one cycle, perform write (per-byte wstrb), go to W_RESP with bvalid=1.
  - W_RESP: hold bvalid/bresp until bready, then W_IDLE.
  - AW without W (or W without AW): wait, no ready.
- Read channel FSM: R_IDLE -> R_RESP.
  - R_IDLE: arvalid -> arready one cycle, capture rdata/rresp, go to R_RESP.
  - R_RESP: hold rvalid/rdata stable until rready, then R_IDLE.
- Latency: ready 1 cycle after valid seen; bvalid/rvalid 1 cycle after ready. One outstanding transaction per channel; read and write channels independent and may complete same cycle.
- Collisions:
  - Software COUNT write same cycle as tick: write wins, no OVF.
  - STATUS W1C same cycle as overflow: set wins (OVF stays 1).
  - CTRL write same cycle as one-shot auto-clear: written value wins.
  - Read of COUNT returns pre-update value of that cycle.
- Reset mid-transaction: all FSMs to idle, valids drop immediately (asynchronous), registers to reset values.

Test Plan:
- Reset -> irq=0, TOP reads 0xFFFFFFFF, CTRL/COUNT/STATUS read 0, bresp/rresp OKAY.
- PRESCALE=3, TOP=4, CTRL=0b011 -> COUNT increments every 4 clks; OVF and irq set after 20 ticks-of-clk (5 counts x 4) plus 1 cycle irq delay; COUNT returns to 0 and keeps running.
- ONESHOT=1, PRESCALE=0, TOP=2 -> OVF after 3 clks, CTRL.EN reads 0, COUNT holds 0.
- Write STATUS=1 with OVF set -> OVF cleared, irq drops next cycle; repeat timed to coincide with overflow -> OVF remains 1.
- Write COUNT=0x12345678 with wstrb=4'b0011 -> COUNT reads 0x00005678 (from 0); read 0x18 -> rresp=SLVERR, rdata=0.
- Delay bready/rready 5 cycles, present AW 3 cycles before W -> no awready until W valid; bvalid/rvalid and data held stable until ready; assert rst_n low mid-response -> bvalid/rvalid fall at once.
